// File: rtl/edge_detect_multi.sv
// edge_detect_multi: per-channel input synchroniser, glitch filter, edge
// qualifier, sticky event flag and saturating event counter, plus a shared
// interrupt built from the sticky flags and the interrupt enables.
module edge_detect_multi #(
   parameter int CH          = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3,
   parameter int CNT_W       = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [CH-1:0]       in_i,
   input  logic [1:0]          mode_i,
   input  logic [CH-1:0]       mask_i,
   input  logic                clr_i,
   output logic [CH-1:0]       pulse_o,
   output logic [CH-1:0]       sticky_o,
   output logic [CH*CNT_W-1:0] count_o,
   output logic                irq_o
);

   // Mismatch counter only needs to hold 0 .. FILT_LEN-1.
   localparam int               FW        = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
   localparam logic [FW-1:0]    FCNT_LAST = FW'(FILT_LEN - 1);
   localparam logic [FW-1:0]    FCNT_ONE  = FW'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   for (genvar g = 0; g < CH; g++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic [FW-1:0]          fcnt_q, fcnt_d;
      logic                   f_q, f_d;
      logic                   f_dly_q;
      logic                   pulse_q, pulse_d;
      logic                   sticky_q, sticky_d;
      logic [CNT_W-1:0]       cnt_q, cnt_d;
      logic                   s_lvl;
      logic                   rise, fall;

      assign s_lvl = sync_q[SYNC_STAGES-1];
      // f_dly_q trails f_q by one cycle, so a difference marks the cycle after a change
      assign rise  = f_q & ~f_dly_q;
      assign fall  = ~f_q & f_dly_q;

      // Next state for synchroniser chain, glitch filter and edge strobe
      always_comb begin
         sync_d  = {sync_q[SYNC_STAGES-2:0], in_i[g]};
         fcnt_d  = {FW{1'b0}};
         f_d     = f_q;
         pulse_d = (rise & mode_i[0]) | (fall & mode_i[1]);
         if (s_lvl != f_q) begin
            if (fcnt_q == FCNT_LAST) begin
               // FILT_LEN-th consecutive mismatch: accept the new level
               f_d    = ~f_q;
               fcnt_d = {FW{1'b0}};
            end else begin
               f_d    = f_q;
               fcnt_d = fcnt_q + FCNT_ONE;
            end
         end else begin
            f_d    = f_q;
            fcnt_d = {FW{1'b0}};
         end
      end

      // Next state for sticky flag and saturating counter; a coincident pulse beats clr
      always_comb begin
         sticky_d = sticky_q;
         cnt_d    = cnt_q;
         if (pulse_q) begin
            sticky_d = 1'b1;
            if (clr_i) begin
               cnt_d = CNT_ONE;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_ONE;
            end else begin
               cnt_d = cnt_q;
            end
         end else if (clr_i) begin
            sticky_d = 1'b0;
            cnt_d    = {CNT_W{1'b0}};
         end else begin
            sticky_d = sticky_q;
            cnt_d    = cnt_q;
         end
      end

      // Channel state registers with asynchronous reset
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            sync_q   <= {SYNC_STAGES{1'b0}};
            fcnt_q   <= {FW{1'b0}};
            f_q      <= 1'b0;
            f_dly_q  <= 1'b0;
            pulse_q  <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
         end else begin
            sync_q   <= sync_d;
            fcnt_q   <= fcnt_d;
            f_q      <= f_d;
            f_dly_q  <= f_q;
            pulse_q  <= pulse_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
         end
      end

      assign pulse_o[g]                 = pulse_q;
      assign sticky_o[g]                = sticky_q;
      assign count_o[g*CNT_W +: CNT_W]  = cnt_q;
   end

   // Interrupt follows sticky flags and enables without an extra register stage
   assign irq_o = |(sticky_o & mask_i);

endmodule

// File: tb/tb_edge_detect_multi.sv
// Bench for edge_detect_multi: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a behavioural model.
module tb_edge_detect_multi;
   localparam int CH = 4, SS = 2, FL = 3, CW = 4;
   localparam int HMASK = (1 << FL) - 1;
   localparam int CMAX  = (1 << CW) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [CH-1:0]    in_v = '0;
   logic [1:0]       mode_v = 2'b00;
   logic [CH-1:0]    mask_v = '0;
   logic             clr_v = 1'b0;
   logic [CH-1:0]    pulse_w, sticky_w;
   logic [CH*CW-1:0] count_w;
   logic             irq_w;

   int n_cmp = 0, n_bad = 0;
   bit chk_en = 1'b0;
   int pcnt [CH];

   // model state
   logic [SS-1:0] m_pipe [CH];
   int m_hist [CH], m_cnt [CH];
   bit m_f [CH], m_rise [CH], m_fall [CH], m_pulse [CH], m_sticky [CH];

   edge_detect_multi #(.CH(CH), .SYNC_STAGES(SS), .FILT_LEN(FL), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst), .in_i(in_v), .mode_i(mode_v), .mask_i(mask_v),
      .clr_i(clr_v), .pulse_o(pulse_w), .sticky_o(sticky_w), .count_o(count_w),
      .irq_o(irq_w));

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", nm, act, req, $time);
      end
   endfunction

   // Behavioural model: level accepted once the last FL synchronised samples all disagree with it
   initial begin
      bit s, tog;
      int h;
      for (int c = 0; c < CH; c++) pcnt[c] = 0;
      forever begin
         @(posedge clk or posedge rst);
         for (int c = 0; c < CH; c++) begin
            if (rst) begin
               m_pipe[c] = '0; m_hist[c] = 0; m_cnt[c] = 0;
               m_f[c] = 0; m_rise[c] = 0; m_fall[c] = 0; m_pulse[c] = 0; m_sticky[c] = 0;
            end else begin
               s   = m_pipe[c][SS-1];
               h   = ((m_hist[c] << 1) | int'(s)) & HMASK;
               tog = m_f[c] ? (h == 0) : (h == HMASK);
               if (m_pulse[c]) begin
                  m_sticky[c] = 1'b1;
                  m_cnt[c] = clr_v ? 1 : ((m_cnt[c] < CMAX) ? m_cnt[c] + 1 : CMAX);
               end else if (clr_v) begin
                  m_sticky[c] = 1'b0;
                  m_cnt[c] = 0;
               end
               m_pulse[c] = (m_rise[c] & mode_v[0]) | (m_fall[c] & mode_v[1]);
               m_rise[c]  = tog & ~m_f[c];
               m_fall[c]  = tog & m_f[c];
               if (tog) m_f[c] = ~m_f[c];
               m_hist[c]  = h;
               m_pipe[c]  = {m_pipe[c][SS-2:0], in_v[c]};
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   initial begin
      logic [CH-1:0] ep, es;
      logic [CH*CW-1:0] ec;
      forever begin
         @(negedge clk);
         for (int c = 0; c < CH; c++) pcnt[c] += int'(pulse_w[c]);
         if (chk_en) begin
            for (int c = 0; c < CH; c++) begin
               ep[c] = m_pulse[c];
               es[c] = m_sticky[c];
               ec[c*CW +: CW] = m_cnt[c][CW-1:0];
            end
            chk("model_pulse", pulse_w, ep);
            chk("model_sticky", sticky_w, es);
            chk("model_count", count_w, ec);
            chk("model_irq", irq_w, |(es & mask_v));
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset();
      in_v = '0; clr_v = 1'b0;
      rst = 1'b1;
      step(2);
      rst = 1'b0;
   endtask

   initial begin
      int base;
      rst = 1'b1;
      step(2);
      chk("reset_pulse", pulse_w, 0);
      chk("reset_sticky", sticky_w, 0);
      chk("reset_count", count_w, 0);
      chk("reset_irq", irq_w, 0);
      chk_en = 1'b1;
      rst = 1'b0;

      // single rising edge, latency 6
      mode_v = 2'b01; mask_v = 4'hF;
      in_v[0] = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         step();
         chk("lat_pulse0", pulse_w[0], (k == 6) ? 1 : 0);
      end
      chk("lat_count0", count_w[3:0], 1);
      chk("lat_sticky0", sticky_w[0], 1);
      chk("lat_irq", irq_w, 1);
      chk("lat_others_sticky", sticky_w[3:1], 0);
      chk("lat_others_count", count_w[15:4], 0);

      // glitch rejection, then a long pulse gives two events
      do_reset();
      mode_v = 2'b11;
      base = pcnt[1];
      in_v[1] = 1'b1; step(2); in_v[1] = 1'b0; step(12);
      chk("glitch_pulses", pcnt[1] - base, 0);
      chk("glitch_count1", count_w[7:4], 0);
      in_v[1] = 1'b1; step(5); in_v[1] = 1'b0; step(12);
      chk("wide_pulses", pcnt[1] - base, 2);
      chk("wide_count1", count_w[7:4], 2);

      // saturation
      do_reset();
      mode_v = 2'b11;
      base = pcnt[2];
      for (int t = 0; t < 20; t++) begin
         in_v[2] = ~in_v[2];
         step(6);
      end
      step(10);
      chk("sat_pulses", pcnt[2] - base, 20);
      chk("sat_count2", count_w[11:8], 15);

      // clr coincident with pulse, then clr alone
      do_reset();
      mode_v = 2'b11;
      for (int t = 0; t < 5; t++) begin
         in_v[3] = ~in_v[3];
         step(8);
      end
      chk("clr_pre_count3", count_w[15:12], 5);
      in_v[3] = ~in_v[3];
      step(6);
      chk("clr_pulse3", pulse_w[3], 1);
      clr_v = 1'b1; step(); clr_v = 1'b0;
      chk("clr_coinc_count3", count_w[15:12], 1);
      chk("clr_coinc_sticky3", sticky_w[3], 1);
      step(2);
      clr_v = 1'b1; step(); clr_v = 1'b0;
      chk("clr_plain_count3", count_w[15:12], 0);
      chk("clr_plain_sticky3", sticky_w[3], 0);

      // reset mid-filter aborts the pending event
      do_reset();
      mode_v = 2'b11; mask_v = 4'hF;
      in_v[0] = 1'b1; step(10);
      in_v[0] = 1'b0; step(4);
      chk("abort_pre_irq", irq_w, 1);
      rst = 1'b1; #1;
      chk("abort_pulse", pulse_w, 0);
      chk("abort_sticky", sticky_w, 0);
      chk("abort_count", count_w, 0);
      chk("abort_irq", irq_w, 0);
      step(); rst = 1'b0;
      base = pcnt[0];
      step(12);
      chk("abort_no_pulse", pcnt[0] - base, 0);

      // input held high across reset release
      rst = 1'b1; in_v = 4'hF; mode_v = 2'b01;
      step(2); rst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         step();
         chk("hold_rise_pulse", pulse_w, (k == 6) ? 4'hF : 4'h0);
      end
      rst = 1'b1; mode_v = 2'b10;
      step(2); rst = 1'b0;
      base = pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3];
      step(10);
      chk("hold_fall_mode_none", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3] - base, 0);

      // randomized run against the model
      do_reset();
      mode_v = 2'b11; mask_v = 4'hF;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int c = 0; c < CH; c++)
            if ($urandom_range(0, 3) == 0) in_v[c] = ~in_v[c];
         if ($urandom_range(0, 49) == 0) mode_v = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 29) == 0) mask_v = 4'($urandom_range(0, 15));
         clr_v = ($urandom_range(0, 39) == 0);
         rst   = ($urandom_range(0, 599) == 0);
         step();
      end
      rst = 1'b0; clr_v = 1'b0;
      step(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
